// File: rtl/adc_capture_avg.sv
// adc_capture_avg: receive-side capture and accumulation of ADC conversions.
// Each trigger event discards the ADC pipeline latency, then captures SAMPLES
// conversions into a buffer. REPEATS trigger events are summed per run, and
// the host reads the sums back through a registered read port.
module adc_capture_avg #(
  parameter int SAMPLES  = 16,
  parameter int PIPE_LAT = 7,
  parameter int REPEATS  = 5,
  parameter int ACC_W    = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_clk,
  input  logic [13:0]      bn,
  input  logic             start,
  input  logic             trig,
  input  logic [7:0]       rd_addr,
  output logic [ACC_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             trig_err
);

  localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int RW = 3;   // rep_cnt spans 0..7
  localparam int SW = 5;   // skip_cnt spans 0..31

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_SKIP = 3'd2,
    S_ACQ  = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [SW-1:0]     skip_q, skip_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              trig_err_q, trig_err_d;
  logic              adc_clk_d_q;
  logic              stb;
  logic              wr_en;
  logic [ACC_W-1:0]  wr_data;
  logic [ACC_W-1:0]  acc_old;
  logic [ACC_W-1:0]  rd_data_q;
  logic [AW-1:0]     rd_idx;
  logic              rd_ok;
  logic              trig_late;
  logic              unused_rd_addr;

  logic [ACC_W-1:0]  mem [0:SAMPLES-1];

  // Capture strobe marks the 1->0 transition of adc_clk; bn is taken in
  // the same clk cycle the strobe is high.
  assign stb = adc_clk_d_q & ~adc_clk;

  // Upper read-address bits beyond the buffer depth are don't-care.
  assign rd_idx         = rd_addr[AW-1:0];
  assign rd_ok          = (int'(rd_idx) < SAMPLES);
  assign unused_rd_addr = &{1'b0, rd_addr};

  // Current buffer word feeding the read-modify-write accumulation.
  assign acc_old = mem[idx_q];

  // A trigger outside ARM/IDLE is a protocol error; it never moves the FSM.
  assign trig_late = trig & ((state_q == S_SKIP) | (state_q == S_ACQ) |
                             (state_q == S_NEXT) | (state_q == S_DONE));

  // Delay adc_clk by one cycle for edge detection (no reset needed: the
  // FSM ignores strobes until a trigger has been accepted).
  always_ff @(posedge clk) begin
    adc_clk_d_q <= adc_clk;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rep_q      <= '0;
      skip_q     <= '0;
      idx_q      <= '0;
      trig_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      skip_q     <= skip_d;
      idx_q      <= idx_d;
      trig_err_q <= trig_err_d;
    end
  end

  // Next-state logic: start always (re)arms a run and wins over trig;
  // otherwise walk ARM -> SKIP -> ACQ -> NEXT per trigger event.
  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    skip_d     = skip_q;
    idx_d      = idx_q;
    trig_err_d = trig_err_q;
    wr_en      = 1'b0;
    wr_data    = '0;

    if (start) begin
      // Buffer is left alone: repeat 0 overwrites every entry.
      state_d    = S_ARM;
      rep_d      = '0;
      skip_d     = '0;
      idx_d      = '0;
      trig_err_d = 1'b0;
    end else begin
      if (trig_late) begin
        trig_err_d = 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          // Waits for start; a stray trigger here is harmless.
        end

        S_ARM: begin
          if (trig) begin
            skip_d = '0;
            idx_d  = '0;
            state_d = (PIPE_LAT == 0) ? S_ACQ : S_SKIP;
          end
        end

        S_SKIP: begin
          if (stb) begin
            skip_d = skip_q + SW'(1);
            if (skip_q == SW'(PIPE_LAT - 1)) begin
              idx_d   = '0;
              state_d = S_ACQ;
            end
          end
        end

        S_ACQ: begin
          if (stb) begin
            wr_en = 1'b1;
            // First repeat overwrites so stale data never needs clearing.
            if (rep_q == '0) begin
              wr_data = ACC_W'(bn);
            end else begin
              wr_data = acc_old + ACC_W'(bn);
            end
            if (idx_q == AW'(SAMPLES - 1)) begin
              state_d = S_NEXT;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end

        S_NEXT: begin
          if (rep_q == RW'(REPEATS - 1)) begin
            state_d = S_DONE;
          end else begin
            rep_d   = rep_q + RW'(1);
            state_d = S_ARM;
          end
        end

        S_DONE: begin
          // Holds the finished buffer until the next start.
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx_q] <= wr_data;
    end
  end

  // Registered read port: one cycle latency, old data on a same-index write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_ok) begin
      rd_data_q <= mem[rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign trig_err = trig_err_q;

endmodule

// File: tb/tb_adc_capture_avg.sv
// Bench for adc_capture_avg: directed runs with a read-back scoreboard.
module tb_adc_capture_avg;

  logic        clk;
  logic        rst;
  logic        adc_clk;
  logic [13:0] bn;
  logic        start;
  logic        trig;
  logic [7:0]  rd_addr;
  logic [16:0] rd_data;
  logic        busy;
  logic        done;
  logic        trig_err;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  logic rd_req = 1'b0;

  // ADC-side stimulus controls (written by the stimulus process only)
  int trig_req_cnt = 0;
  int bn_const     = 0;
  bit ramp_mode    = 1'b0;
  int err_gap      = 0;

  adc_capture_avg dut (
    .clk      (clk),
    .rst      (rst),
    .adc_clk  (adc_clk),
    .bn       (bn),
    .start    (start),
    .trig     (trig),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .trig_err (trig_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, expv);
    end
  endtask

  // ADC model: 20-cycle adc_clk, bn changes on the rising half so it is
  // stable at each falling-edge strobe; triggers align to the rising edge.
  initial begin
    int ph;
    int ramp;
    int since;
    int fired;
    ph = 0; ramp = 0; since = 1000000; fired = 0;
    adc_clk = 1'b1;
    trig = 1'b0;
    bn = '0;
    forever begin
      @(posedge clk);
      #1;
      trig = 1'b0;
      since++;
      ph = (ph == 19) ? 0 : ph + 1;
      adc_clk = (ph < 10);
      if (err_gap != 0 && since == err_gap) trig = 1'b1;
      if (ph == 0) begin
        if (trig_req_cnt != fired) begin
          trig = 1'b1;
          fired++;
          ramp = 0;
          since = 0;
        end
        bn = ramp_mode ? 14'(ramp) : 14'(bn_const);
        ramp++;
      end
    end
  end

  // Monitor: a read issued in one cycle is checked against rd_data next cycle.
  initial begin
    logic pend;
    int e;
    forever begin
      @(posedge clk);
      pend = rd_req;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic fire_trig(input int wait_cycles);
    trig_req_cnt++;
    cyc(wait_cycles);
  endtask

  task automatic full_run();
    pulse_start();
    for (int r = 0; r < 5; r++) fire_trig(500);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(done), 32'd1);
  endtask

  task automatic read_all(input int base, input int step);
    int k;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 8'(i);
      exp_q.push_back(base + step * i);
      rd_req = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rd_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rd_addr = '0;
    cyc(3);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig_err", 32'(trig_err), 32'd0);
    rst = 1'b0;

    // Trigger while idle: ignored, not flagged
    fire_trig(30);
    check("idle_trig_err", 32'(trig_err), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic run: 5 x 100
    bn_const = 100;
    cyc(25);
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    for (int r = 0; r < 5; r++) fire_trig(500);
    wait_done();
    check("basic_busy", 32'(busy), 32'd0);
    check("basic_trig_err", 32'(trig_err), 32'd0);
    read_all(500, 0);

    // Pipeline skip: ramp 0,1,2.. per trigger, 7 discarded -> 5*(7+i)
    ramp_mode = 1'b1;
    cyc(25);
    full_run();
    wait_done();
    read_all(35, 5);

    // Overflow bound: full-scale input
    ramp_mode = 1'b0;
    bn_const = 16383;
    cyc(25);
    full_run();
    wait_done();
    read_all(81915, 0);

    // Trigger error: extra trigger 50 cycles into the first event
    bn_const = 200;
    cyc(25);
    pulse_start();
    err_gap = 50;
    fire_trig(80);
    err_gap = 0;
    check("err_set", 32'(trig_err), 32'd1);
    check("err_busy", 32'(busy), 32'd1);
    cyc(420);
    for (int r = 0; r < 4; r++) fire_trig(500);
    wait_done();
    check("err_sticky", 32'(trig_err), 32'd1);
    read_all(1000, 0);

    // Abort during repeat 2, then a clean run with bn=10
    bn_const = 1000;
    cyc(25);
    pulse_start();
    fire_trig(500);
    fire_trig(500);
    fire_trig(250);
    bn_const = 10;
    cyc(25);
    check("abort_busy_pre", 32'(busy), 32'd1);
    pulse_start();
    check("abort_busy_post", 32'(busy), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    for (int r = 0; r < 5; r++) fire_trig(500);
    wait_done();
    check("abort_trig_err", 32'(trig_err), 32'd0);
    read_all(50, 0);

    // Reset in the middle of acquisition
    pulse_start();
    fire_trig(250);
    check("midrst_busy_pre", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_trig_err", 32'(trig_err), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    cyc(50);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
